// File: rtl/palette_pkg.sv
// Shared constants, types and helpers for the palette write controller.
package palette_pkg;

    localparam int PAL_ENTRIES    = 512;
    localparam int PAL_HALF_ADR_W = 10;

    localparam logic [PAL_HALF_ADR_W-1:0] CLR_LAST_IDX = PAL_HALF_ADR_W'(2 * PAL_ENTRIES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        CLEAR
    } pwc_state_t;

    typedef struct packed {
        logic [PAL_HALF_ADR_W-1:0] adr;
        logic [15:0]               dat;
    } pal_wr_t;

    // Odd half-word addresses hold the red byte only, zero-extended.
    function automatic logic [15:0] clr_half(input logic [23:0] colour, input logic odd);
        return odd ? {8'h00, colour[23:16]} : colour[15:0];
    endfunction

endpackage

// File: rtl/palette_write_ctrl_if.sv
// CPU write request bus and palette RAM write port seen by the controller.
interface palette_write_ctrl_if;
    import palette_pkg::*;

    logic                      cpu_valid;
    logic                      cpu_ready;
    logic [PAL_HALF_ADR_W-1:0] cpu_adr;
    logic [15:0]               cpu_dat;

    logic                      pal_we;
    logic [PAL_HALF_ADR_W-1:0] pal_adr;
    logic [15:0]               pal_dat;

    modport master (
        output cpu_valid, cpu_adr, cpu_dat,
        input  cpu_ready, pal_we, pal_adr, pal_dat
    );

    modport slave (
        input  cpu_valid, cpu_adr, cpu_dat,
        output cpu_ready, pal_we, pal_adr, pal_dat
    );

endinterface

// File: rtl/pal_wr_fifo.sv
// Register-based FIFO of pending palette half-word writes.
module pal_wr_fifo
    import palette_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  pal_wr_t       push_data_i,
    input  logic          pop_i,
    output pal_wr_t       head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);

    pal_wr_t       mem_q [DEPTH];
    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full_o  = (wr_ptr_q[LW-1] != rd_ptr_q[LW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push  = push_i & ~full_o;
    assign do_pop   = pop_i & ~empty_o;
    assign wr_ptr_d = wr_ptr_q + LW'(do_push);
    assign rd_ptr_d = rd_ptr_q + LW'(do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/palette_write_ctrl.sv
// Buffers CPU palette writes and drains them during blanking; also runs the
// bulk clear that fills every palette entry with one colour.
module palette_write_ctrl
    import palette_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    palette_write_ctrl_if.slave  bus,
    input  logic                 blank_i,
    input  logic                 defer_en_i,
    input  logic                 clr_req_i,
    input  logic [23:0]          clr_colour_i,
    output logic                 clr_busy_o,
    output logic [LW-1:0]        fifo_level_o
);

    pwc_state_t                state_q;
    logic [PAL_HALF_ADR_W-1:0] idx_q, idx_d;
    logic [23:0]               colour_q;
    logic                      clr_busy_q;
    logic                      pal_we_q;
    logic [PAL_HALF_ADR_W-1:0] pal_adr_q;
    logic [15:0]               pal_dat_q;

    logic                      go;
    logic                      accept;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    pal_wr_t                   push_data;
    pal_wr_t                   head;

    assign go            = blank_i | ~defer_en_i;
    assign bus.cpu_ready = (state_q == IDLE) & ~fifo_full & rst;
    assign accept        = bus.cpu_valid & bus.cpu_ready;
    assign pop           = (state_q != CLEAR) & ~fifo_empty & go;
    assign push_data     = '{adr: bus.cpu_adr, dat: bus.cpu_dat};
    assign idx_d         = idx_q + PAL_HALF_ADR_W'(1);

    pal_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level_o)
    );

    // A clear never starts while CPU writes are still queued, so the fill
    // always lands after (and is never overwritten by) earlier CPU data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            colour_q   <= '0;
            clr_busy_q <= 1'b0;
            pal_we_q   <= 1'b0;
            pal_adr_q  <= '0;
            pal_dat_q  <= '0;
        end else begin
            pal_we_q <= 1'b0;
            if (pop) begin
                pal_we_q  <= 1'b1;
                pal_adr_q <= head.adr;
                pal_dat_q <= head.dat;
            end
            case (state_q)
                IDLE: begin
                    if (clr_req_i) begin
                        colour_q   <= clr_colour_i;
                        clr_busy_q <= 1'b1;
                        idx_q      <= '0;
                        state_q    <= (fifo_empty && !accept) ? CLEAR : FLUSH;
                    end
                end
                FLUSH: begin
                    if (fifo_empty) begin
                        idx_q   <= '0;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (go) begin
                        pal_we_q  <= 1'b1;
                        pal_adr_q <= idx_q;
                        pal_dat_q <= clr_half(colour_q, idx_q[0]);
                        idx_q     <= idx_d;
                        if (idx_q == CLR_LAST_IDX) begin
                            state_q    <= IDLE;
                            clr_busy_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pal_we  = pal_we_q;
    assign bus.pal_adr = pal_adr_q;
    assign bus.pal_dat = pal_dat_q;
    assign clr_busy_o  = clr_busy_q;

endmodule

// File: tb/tb_palette_write_ctrl.sv
// Directed bench for palette_write_ctrl: a queue-based reference model is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_palette_write_ctrl;

    localparam int DEPTH   = 16;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int LOG_MAX = 4096;

    logic          clk;
    logic          rst;
    logic          blank;
    logic          deferEn;
    logic          clrReq;
    logic [23:0]   clrColour;
    logic          clrBusy;
    logic [LW-1:0] fifoLevel;

    palette_write_ctrl_if bus();

    palette_write_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .blank_i      (blank),
        .defer_en_i   (deferEn),
        .clr_req_i    (clrReq),
        .clr_colour_i (clrColour),
        .clr_busy_o   (clrBusy),
        .fifo_level_o (fifoLevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errorCount = 0;
    int checkCount = 0;
    int cycleCount = 0;

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: a plain queue of pending writes plus a clear cursor.
    typedef struct {
        logic [9:0]  adr;
        logic [15:0] dat;
    } modelWr_t;

    modelWr_t    modelQ[$];
    int          modelMode;
    int          clrIdx;
    logic [23:0] modelColour;
    logic        expBusy;
    logic        expWe;
    logic [9:0]  expAdr;
    logic [15:0] expDat;

    logic [9:0]  logAdr  [LOG_MAX];
    logic [15:0] logDat  [LOG_MAX];
    int          logCyc  [LOG_MAX];
    logic        logBusy [LOG_MAX];
    int          logCount = 0;
    int          maxLevel = 0;

    always @(negedge clk) begin
        bit       go;
        bit       accept;
        int       sizeBefore;
        int       nextMode;
        modelWr_t w;
        if (!rst) begin
            modelQ.delete();
            modelMode   = 0;
            clrIdx      = 0;
            modelColour = '0;
            expBusy     = 1'b0;
            expWe       = 1'b0;
            expAdr      = '0;
            expDat      = '0;
            checkOutput("reset pal_we", bus.pal_we, 0);
            checkOutput("reset pal_adr", bus.pal_adr, 0);
            checkOutput("reset pal_dat", bus.pal_dat, 0);
            checkOutput("reset clr_busy", clrBusy, 0);
            checkOutput("reset fifo_level", fifoLevel, 0);
            checkOutput("reset cpu_ready", bus.cpu_ready, 0);
        end else begin
            checkOutput("model pal_we", bus.pal_we, expWe);
            checkOutput("model pal_adr", bus.pal_adr, expAdr);
            checkOutput("model pal_dat", bus.pal_dat, expDat);
            checkOutput("model clr_busy", clrBusy, expBusy);
            checkOutput("model fifo_level", fifoLevel, modelQ.size());
            checkOutput("model cpu_ready", bus.cpu_ready, (modelMode == 0 && modelQ.size() < DEPTH));
            if (bus.pal_we === 1'b1 && logCount < LOG_MAX) begin
                logAdr[logCount]  = bus.pal_adr;
                logDat[logCount]  = bus.pal_dat;
                logCyc[logCount]  = cycleCount;
                logBusy[logCount] = clrBusy;
                logCount++;
            end
            if (int'(fifoLevel) > maxLevel) maxLevel = int'(fifoLevel);

            // Predict what the coming clock edge must produce.
            go         = blank | ~deferEn;
            accept     = bus.cpu_valid && modelMode == 0 && modelQ.size() < DEPTH;
            sizeBefore = modelQ.size();
            nextMode   = modelMode;
            expWe      = 1'b0;
            if (modelMode != 2) begin
                if (sizeBefore > 0 && go) begin
                    w      = modelQ.pop_front();
                    expWe  = 1'b1;
                    expAdr = w.adr;
                    expDat = w.dat;
                end
                if (modelMode == 0 && clrReq) begin
                    modelColour = clrColour;
                    expBusy     = 1'b1;
                    clrIdx      = 0;
                    nextMode    = (sizeBefore == 0 && !accept) ? 2 : 1;
                end
                if (modelMode == 1 && sizeBefore == 0) begin
                    clrIdx   = 0;
                    nextMode = 2;
                end
            end else if (go) begin
                expWe  = 1'b1;
                expAdr = clrIdx[9:0];
                expDat = (clrIdx % 2 == 1) ? {8'h00, modelColour[23:16]} : modelColour[15:0];
                clrIdx++;
                if (clrIdx == 1024) begin
                    nextMode = 0;
                    expBusy  = 1'b0;
                end
            end
            if (accept) begin
                w.adr = bus.cpu_adr;
                w.dat = bus.cpu_dat;
                modelQ.push_back(w);
            end
            modelMode = nextMode;
        end
    end

    int lastAcceptCycle = 0;

    // Present one CPU write from posedge+1 and hold it until accepted.
    task automatic applyStimulus(input logic [9:0] adr, input logic [15:0] dat);
        bit done;
        done          = 1'b0;
        bus.cpu_valid = 1'b1;
        bus.cpu_adr   = adr;
        bus.cpu_dat   = dat;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            #1;
            if (bus.cpu_ready === 1'b1) begin
                @(posedge clk);
                #1;
                lastAcceptCycle = cycleCount;
                done = 1'b1;
            end
        end
        if (!done) checkOutput("write accept timeout", 0, 1);
        bus.cpu_valid = 1'b0;
    endtask

    task automatic nextCycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int acc1;
        int acc2;
        int bad;
        int budget;

        rst           = 1'b0;
        blank         = 1'b0;
        deferEn       = 1'b0;
        clrReq        = 1'b0;
        clrColour     = '0;
        bus.cpu_valid = 1'b0;
        bus.cpu_adr   = '0;
        bus.cpu_dat   = '0;
        #3;
        checkOutput("por pal_we", bus.pal_we, 0);
        checkOutput("por cpu_ready", bus.cpu_ready, 0);
        checkOutput("por fifo_level", fifoLevel, 0);
        nextCycle(3);
        rst = 1'b1;
        nextCycle(1);

        // Back-to-back writes with no deferral.
        base     = logCount;
        maxLevel = 0;
        applyStimulus(10'h002, 16'h1234);
        acc1 = lastAcceptCycle;
        applyStimulus(10'h003, 16'h00AB);
        acc2 = lastAcceptCycle;
        nextCycle(4);
        checkOutput("t1 write count", logCount - base, 2);
        checkOutput("t1 first adr", logAdr[base], 10'h002);
        checkOutput("t1 first dat", logDat[base], 16'h1234);
        checkOutput("t1 second adr", logAdr[base+1], 10'h003);
        checkOutput("t1 second dat", logDat[base+1], 16'h00AB);
        checkOutput("t1 first latency", logCyc[base] - acc1, 1);
        checkOutput("t1 second latency", logCyc[base+1] - acc2, 1);
        checkOutput("t1 peak level", maxLevel, 1);

        // Fill the FIFO while deferred, then drain during blanking.
        deferEn = 1'b1;
        nextCycle(1);
        base = logCount;
        for (int i = 0; i < 16; i++) applyStimulus(10'(12'h100 + i), 16'(16'h5000 + i));
        bus.cpu_valid = 1'b1;
        bus.cpu_adr   = 10'h1FF;
        bus.cpu_dat   = 16'hDEAD;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("t2 cpu_ready when full", bus.cpu_ready, 0);
        checkOutput("t2 level when full", fifoLevel, 16);
        checkOutput("t2 no writes while deferred", logCount - base, 0);
        @(posedge clk);
        #1;
        bus.cpu_valid = 1'b0;
        blank         = 1'b1;
        nextCycle(5);
        blank = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("t2 level after 5 blank cycles", fifoLevel, 11);
        checkOutput("t2 writes after 5 blank cycles", logCount - base, 5);
        @(posedge clk);
        #1;
        blank = 1'b1;
        nextCycle(13);
        blank = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("t2 level drained", fifoLevel, 0);
        checkOutput("t2 total writes", logCount - base, 16);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (logAdr[base+i] !== 10'(12'h100 + i) || logDat[base+i] !== 16'(16'h5000 + i)) bad++;
        end
        checkOutput("t2 drain order errors", bad, 0);

        // Push and pop on the same edge at level 3.
        @(posedge clk);
        #1;
        base = logCount;
        for (int i = 0; i < 3; i++) applyStimulus(10'(12'h200 + i), 16'(16'h7000 + i));
        blank = 1'b1;
        applyStimulus(10'h203, 16'h7003);
        @(negedge clk);
        #1;
        checkOutput("t3 level after push+pop", fifoLevel, 3);
        nextCycle(6);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (logAdr[base+i] !== 10'(12'h200 + i) || logDat[base+i] !== 16'(16'h7000 + i)) bad++;
        end
        checkOutput("t3 write count", logCount - base, 4);
        checkOutput("t3 order errors", bad, 0);

        // Clear with two writes still queued, with blank toggling mid-clear.
        blank = 1'b0;
        applyStimulus(10'h010, 16'h1111);
        applyStimulus(10'h011, 16'h0022);
        base      = logCount;
        blank     = 1'b1;
        clrReq    = 1'b1;
        clrColour = 24'hABCDEF;
        nextCycle(1);
        clrReq = 1'b0;
        budget = 0;
        while (logCount < base + 302 && budget < 2000) begin
            @(negedge clk);
            #1;
            budget++;
        end
        checkOutput("t4 reached idx 300", (logCount >= base + 302), 1);
        @(posedge clk);
        #1;
        blank = 1'b0;
        nextCycle(3);
        blank = 1'b1;
        nextCycle(2);
        blank = 1'b0;
        nextCycle(4);
        blank = 1'b1;
        budget = 0;
        while (clrBusy !== 1'b0 && budget < 3000) begin
            @(negedge clk);
            #1;
            budget++;
        end
        checkOutput("t4 clear finished", clrBusy, 0);
        checkOutput("t4 total writes", logCount - base, 1026);
        checkOutput("t4 flushed adr 0", logAdr[base], 10'h010);
        checkOutput("t4 flushed dat 0", logDat[base], 16'h1111);
        checkOutput("t4 flushed adr 1", logAdr[base+1], 10'h011);
        checkOutput("t4 flushed dat 1", logDat[base+1], 16'h0022);
        checkOutput("t4 clear idx0 dat", logDat[base+2], 16'hCDEF);
        checkOutput("t4 clear idx1 dat", logDat[base+3], 16'h00AB);
        bad = 0;
        for (int k = 0; k < 1024; k++) begin
            if (logAdr[base+2+k] !== 10'(k)) bad++;
            if (logDat[base+2+k] !== ((k % 2 == 1) ? 16'h00AB : 16'hCDEF)) bad++;
        end
        checkOutput("t4 clear sequence errors", bad, 0);
        checkOutput("t4 busy at adr 1022 write", logBusy[base+1024], 1);
        checkOutput("t4 busy at adr 1023 write", logBusy[base+1025], 0);

        // Reset in the middle of a clear.
        @(posedge clk);
        #1;
        clrReq    = 1'b1;
        clrColour = 24'h123456;
        nextCycle(1);
        clrReq = 1'b0;
        budget = 0;
        while (!(bus.pal_we === 1'b1 && bus.pal_adr === 10'd500) && budget < 1500) begin
            @(negedge clk);
            #1;
            budget++;
        end
        checkOutput("t5 reached idx 500", bus.pal_adr, 10'd500);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("t5 pal_we in reset", bus.pal_we, 0);
        checkOutput("t5 clr_busy in reset", clrBusy, 0);
        checkOutput("t5 level in reset", fifoLevel, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("t5 cpu_ready after reset", bus.cpu_ready, 1);
        checkOutput("t5 clr_busy after reset", clrBusy, 0);
        @(posedge clk);
        #1;
        base = logCount;
        applyStimulus(10'h055, 16'hBEEF);
        nextCycle(3);
        checkOutput("t5 post-reset write count", logCount - base, 1);
        checkOutput("t5 post-reset adr", logAdr[base], 10'h055);
        checkOutput("t5 post-reset dat", logDat[base], 16'hBEEF);

        nextCycle(2);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
